// File: rtl/aoc_mem_pkg.sv
// Shared constants and the fetch-state type for the BITS word-memory reader.
package aoc_mem_pkg;

   localparam int MEM_AW    = 10;
   localparam int MEM_DW    = 32;
   localparam int MAX_FIELD = 15;
   localparam int NB_W      = 4;
   localparam int POS_W     = 16;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_CAPT  = 2'd3
   } fetch_state_t;

endpackage

// File: rtl/bit_shift_buf.sv
// Left-aligned bit buffer: fields leave from the top, new words land just below
// the valid bits. Bits below `fill` are always zero, so appends can simply OR in.
module bit_shift_buf
   import aoc_mem_pkg::*;
#(
   parameter int DATA_W = MEM_DW,
   localparam int BUF_W  = 2 * DATA_W,
   localparam int FILL_W = $clog2(BUF_W) + 1
) (
   input  logic                 clk,
   input  logic                 resetb,
   input  logic                 flush,
   input  logic                 take,
   input  logic [NB_W-1:0]      take_n,
   input  logic                 append,
   input  logic [DATA_W-1:0]    append_data,
   output logic [FILL_W-1:0]    fill,
   output logic [MAX_FIELD-1:0] field
);

   logic [BUF_W-1:0]  data_q;
   logic [BUF_W-1:0]  kept;
   logic [BUF_W-1:0]  incoming;
   logic [FILL_W-1:0] fill_kept;

   // A same-edge take and append: shift out first, then place the word at the new fill.
   always_comb begin
      kept      = data_q;
      fill_kept = fill;
      if (take) begin
         kept      = data_q << take_n;
         fill_kept = fill - FILL_W'(take_n);
      end
      incoming = {append_data, {DATA_W{1'b0}}} >> fill_kept;
   end

   assign field = data_q[BUF_W-1 -: MAX_FIELD] >> (NB_W'(MAX_FIELD) - take_n);

   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         data_q <= '0;
         fill   <= '0;
      end else if (flush) begin
         data_q <= '0;
         fill   <= '0;
      end else if (append) begin
         data_q <= kept | incoming;
         fill   <= fill_kept + FILL_W'(DATA_W);
      end else begin
         data_q <= kept;
         fill   <= fill_kept;
      end
   end

endmodule

// File: rtl/bits_mem_reader.sv
// Read-only memory initiator that streams a word run into MSB-first bit fields
// for the packet decoder over a req/valid handshake.
module bits_mem_reader
   import aoc_mem_pkg::*;
#(
   parameter int ADDR_W = MEM_AW,
   parameter int DATA_W = MEM_DW
) (
   input  logic                 clk,
   input  logic                 resetb,
   input  logic                 start,
   input  logic [ADDR_W-1:0]    base_addr,
   input  logic [ADDR_W:0]      word_count,
   output logic                 mem_ceb,
   output logic                 mem_web,
   output logic [ADDR_W-1:0]    mem_addr,
   output logic [DATA_W-1:0]    mem_wdata,
   input  logic [DATA_W-1:0]    mem_rdata,
   input  logic                 bit_req,
   input  logic [NB_W-1:0]      bit_nbits,
   output logic                 bit_valid,
   output logic [MAX_FIELD-1:0] bit_data,
   output logic [POS_W-1:0]     bit_pos,
   output logic                 busy,
   output logic                 done,
   output logic                 err
);

   localparam int FILL_W = $clog2(2 * DATA_W) + 1;
   localparam logic [ADDR_W:0]   ONE_CNT  = 1;
   localparam logic [ADDR_W-1:0] ONE_ADDR = 1;

   fetch_state_t         state;
   logic [ADDR_W:0]      remaining;
   logic [ADDR_W-1:0]    next_addr;
   logic [FILL_W-1:0]    fill;
   logic [MAX_FIELD-1:0] field;
   logic                 grant;
   logic                 capture;
   logic                 issue;
   logic                 drained;
   logic                 err_cond;

   // WAIT is the cycle mem_ceb is low, CAPT the cycle read data is on mem_rdata.
   assign grant    = busy && bit_req && !bit_valid && (bit_nbits != '0)
                     && (fill >= FILL_W'(bit_nbits)) && !start;
   assign capture  = busy && (state == ST_CAPT) && !start;
   assign issue    = (state == ST_ISSUE) && (remaining != '0)
                     && (fill <= FILL_W'(DATA_W));
   assign drained  = (state == ST_ISSUE) && (remaining == '0) && (fill == '0);
   assign err_cond = busy && bit_req && !bit_valid
                     && ((bit_nbits == '0)
                         || ((fill < FILL_W'(bit_nbits)) && (remaining == '0)
                             && (state == ST_ISSUE)));

   bit_shift_buf #(.DATA_W(DATA_W)) u_buf (
      .clk         (clk),
      .resetb      (resetb),
      .flush       (start),
      .take        (grant),
      .take_n      (bit_nbits),
      .append      (capture),
      .append_data (mem_rdata),
      .fill        (fill),
      .field       (field)
   );

   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         state     <= ST_IDLE;
         remaining <= '0;
         next_addr <= '0;
         mem_ceb   <= 1'b1;
         mem_web   <= 1'b1;
         mem_addr  <= '0;
         mem_wdata <= '0;
         bit_valid <= 1'b0;
         bit_data  <= '0;
         bit_pos   <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
      end else begin
         mem_ceb   <= 1'b1;
         mem_web   <= 1'b1;
         mem_wdata <= '0;
         bit_valid <= 1'b0;
         if (start) begin
            err     <= 1'b0;
            bit_pos <= '0;
            if (word_count == '0) begin
               state <= ST_IDLE;
               busy  <= 1'b0;
               done  <= 1'b1;
            end else begin
               // The first read goes out on the start edge itself.
               state     <= ST_WAIT;
               busy      <= 1'b1;
               done      <= 1'b0;
               mem_ceb   <= 1'b0;
               mem_addr  <= base_addr;
               next_addr <= base_addr + ONE_ADDR;
               remaining <= word_count - ONE_CNT;
            end
         end else if (busy) begin
            case (state)
               ST_IDLE: ;
               ST_ISSUE: begin
                  if (drained) begin
                     state <= ST_IDLE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end else if (issue) begin
                     state     <= ST_WAIT;
                     mem_ceb   <= 1'b0;
                     mem_addr  <= next_addr;
                     next_addr <= next_addr + ONE_ADDR;
                     remaining <= remaining - ONE_CNT;
                  end
               end
               ST_WAIT: state <= ST_CAPT;
               ST_CAPT: state <= ST_ISSUE;
            endcase
            if (grant) begin
               bit_valid <= 1'b1;
               bit_data  <= field;
               bit_pos   <= bit_pos + POS_W'(bit_nbits);
            end
            if (err_cond) err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_bits_mem_reader.sv
// Scoreboard bench: requests push model-derived fields, a negedge monitor pops and compares.
module tb_bits_mem_reader;

   logic        clk = 1'b0;
   logic        resetb = 1'b0;
   logic        start = 1'b0;
   logic [9:0]  base_addr = '0;
   logic [10:0] word_count = '0;
   logic        mem_ceb, mem_web;
   logic [9:0]  mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata = '0;
   logic        bit_req = 1'b0;
   logic [3:0]  bit_nbits = '0;
   logic        bit_valid;
   logic [14:0] bit_data;
   logic [15:0] bit_pos;
   logic        busy, done, err;

   bits_mem_reader #(.ADDR_W(10), .DATA_W(32)) dut (
      .clk(clk), .resetb(resetb), .start(start), .base_addr(base_addr),
      .word_count(word_count), .mem_ceb(mem_ceb), .mem_web(mem_web),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .bit_req(bit_req), .bit_nbits(bit_nbits), .bit_valid(bit_valid),
      .bit_data(bit_data), .bit_pos(bit_pos), .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [14:0] f;
      logic [15:0] p;
   } exp_t;

   int          vectors = 0;
   int          miscompares = 0;
   logic [31:0] mem [1024];
   logic [31:0] mwords [$];
   int          mpos;
   exp_t        exp_q [$];
   logic [9:0]  rd_addrs [$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      vectors++;
      if (act !== expv) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
      end
   endtask

   // Memory: registered read data the cycle after a ceb-low edge
   always @(posedge clk) begin
      if (resetb && !mem_ceb) begin
         mem_rdata <= mem[mem_addr];
         rd_addrs.push_back(mem_addr);
      end
   end

   // Monitor
   always @(negedge clk) begin
      if (resetb && bit_valid) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_valid", {17'b0, bit_data}, 32'hFFFF_FFFF);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("bit_data", {17'b0, bit_data}, {17'b0, e.f});
            chk("bit_pos", {16'b0, bit_pos}, {16'b0, e.p});
         end
      end
   end

   // Reference: the run is a plain bit string, bit k = word[k/32] bit (31 - k%32)
   function automatic logic [14:0] model_field(input int n);
      logic [14:0] f;
      logic [31:0] w;
      int          b;
      f = '0;
      for (int i = 0; i < n; i++) begin
         b = mpos + i;
         w = mwords[b / 32];
         f = {f[13:0], w[31 - (b % 32)]};
      end
      return f;
   endfunction

   task automatic do_start(input int base, input int cnt);
      @(negedge clk);
      start = 1'b1;
      base_addr = base[9:0];
      word_count = cnt[10:0];
      @(posedge clk);
      #1;
      start = 1'b0;
      mwords.delete();
      for (int i = 0; i < cnt; i++) mwords.push_back(mem[(base + i) % 1024]);
      mpos = 0;
      exp_q.delete();
      rd_addrs.delete();
   endtask

   task automatic do_req(input int n, output int lat);
      exp_t e;
      bit   got;
      e.f = model_field(n);
      e.p = 16'(mpos + n);
      mpos += n;
      exp_q.push_back(e);
      bit_nbits = n[3:0];
      bit_req = 1'b1;
      lat = 0;
      got = 1'b0;
      while (!got && lat < 200) begin
         @(posedge clk);
         #1;
         lat++;
         if (bit_valid) got = 1'b1;
      end
      bit_req = 1'b0;
      if (!got) begin
         chk("req_timeout", {31'b0, got}, 32'd1);
         exp_q.delete();
      end
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_done(input string tag);
      int k;
      k = 0;
      while (!done && k < 30) begin
         @(posedge clk);
         #1;
         k++;
      end
      chk({tag, "_done"}, {31'b0, done}, 32'd1);
      chk({tag, "_busy"}, {31'b0, busy}, 32'd0);
      chk({tag, "_err"}, {31'b0, err}, 32'd0);
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_ceb"}, {31'b0, mem_ceb}, 32'd1);
      chk({tag, "_web"}, {31'b0, mem_web}, 32'd1);
      chk({tag, "_addr"}, {22'b0, mem_addr}, 32'd0);
      chk({tag, "_wdata"}, mem_wdata, 32'd0);
      chk({tag, "_valid"}, {31'b0, bit_valid}, 32'd0);
      chk({tag, "_data"}, {17'b0, bit_data}, 32'd0);
      chk({tag, "_pos"}, {16'b0, bit_pos}, 32'd0);
      chk({tag, "_busy"}, {31'b0, busy}, 32'd0);
      chk({tag, "_done"}, {31'b0, done}, 32'd0);
      chk({tag, "_err"}, {31'b0, err}, 32'd0);
   endtask

   initial begin
      #500_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      int rem;
      int n;
      int base;
      int cnt;
      for (int i = 0; i < 1024; i++) mem[i] = $urandom;
      mem[0]    = 32'hD2FE_2800;
      mem[100]  = 32'hFFFF_FFF0;
      mem[101]  = 32'hA000_0000;
      mem[200]  = 32'h1234_5678;
      mem[10]   = 32'hAAAA_5555;
      mem[20]   = 32'h3C3C_0F0F;

      wait_cycles(3);
      check_reset_vals("reset");
      @(negedge clk);
      resetb = 1'b1;
      wait_cycles(2);

      // Single-word decode with first-grant latency
      do_start(0, 1);
      chk("first_ceb", {31'b0, mem_ceb}, 32'd0);
      chk("first_addr", {22'b0, mem_addr}, 32'd0);
      chk("first_busy", {31'b0, busy}, 32'd1);
      do_req(3, lat);
      chk("first_latency", lat, 32'd3);
      do_req(3, lat);
      do_req(5, lat);
      do_req(5, lat);
      do_req(5, lat);
      wait_cycles(2);
      chk("single_pos", {16'b0, bit_pos}, 32'd21);

      // Word straddle
      do_start(100, 2);
      do_req(15, lat);
      do_req(15, lat);
      do_req(5, lat);
      wait_cycles(6);
      chk("straddle_reads", rd_addrs.size(), 32'd2);

      // Underrun
      do_start(200, 1);
      do_req(15, lat);
      do_req(15, lat);
      bit_nbits = 4'd4;
      bit_req = 1'b1;
      wait_cycles(10);
      chk("underrun_err", {31'b0, err}, 32'd1);
      chk("underrun_busy", {31'b0, busy}, 32'd1);
      chk("underrun_done", {31'b0, done}, 32'd0);
      bit_req = 1'b0;
      wait_cycles(2);

      // Zero-width request
      do_start(400, 1);
      chk("start_clears_err", {31'b0, err}, 32'd0);
      wait_cycles(3);
      bit_nbits = 4'd0;
      bit_req = 1'b1;
      wait_cycles(4);
      chk("nbits0_err", {31'b0, err}, 32'd1);
      bit_req = 1'b0;
      wait_cycles(2);

      // Address wrap and completion
      do_start(1023, 2);
      for (int i = 0; i < 32; i++) do_req(2, lat);
      wait_done("wrap");
      chk("wrap_reads", rd_addrs.size(), 32'd2);
      if (rd_addrs.size() == 2) begin
         chk("wrap_addr0", {22'b0, rd_addrs[0]}, 32'd1023);
         chk("wrap_addr1", {22'b0, rd_addrs[1]}, 32'd0);
      end

      // Zero word count
      do_start(5, 0);
      chk("wc0_done", {31'b0, done}, 32'd1);
      chk("wc0_busy", {31'b0, busy}, 32'd0);
      wait_cycles(4);
      chk("wc0_reads", rd_addrs.size(), 32'd0);

      // Restart while the first read is outstanding
      do_start(10, 2);
      do_start(20, 2);
      do_req(15, lat);
      do_req(10, lat);
      chk("restart_reads_nonzero", {31'b0, rd_addrs.size() != 0}, 32'd1);
      if (rd_addrs.size() != 0) chk("restart_addr", {22'b0, rd_addrs[0]}, 32'd20);

      // Async reset mid-run
      do_start(300, 3);
      do_req(5, lat);
      do_req(7, lat);
      @(posedge clk);
      #3;
      resetb = 1'b0;
      #1;
      check_reset_vals("async");
      exp_q.delete();
      @(negedge clk);
      resetb = 1'b1;
      wait_cycles(2);

      // Randomized runs to completion
      for (int r = 0; r < 8; r++) begin
         base = $urandom_range(0, 1023);
         cnt = $urandom_range(1, 4);
         do_start(base, cnt);
         rem = 32 * cnt;
         while (rem > 0) begin
            n = $urandom_range(1, (rem < 15) ? rem : 15);
            do_req(n, lat);
            rem -= n;
            if ($urandom_range(0, 3) == 0) wait_cycles($urandom_range(1, 5));
         end
         wait_done("rand");
         chk("rand_reads", rd_addrs.size(), cnt);
      end

      wait_cycles(3);
      chk("scoreboard_empty", exp_q.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
